// File: rtl/fb_port_if.sv
// fb_port_if: writer, reader and RAM-side signals of the framebuffer port arbiter
interface fb_port_if #(parameter int AW = 12, parameter int LW = 3);
  localparam int WW = AW - 1;
  logic wr_valid;
  logic wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic rd_req;
  logic rd_ack;
  logic [WW-1:0] rd_addr;
  logic [15:0] rd_data;
  logic rd_data_valid;
  logic [WW-1:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0] mem_byte_en;
  logic mem_we;
  logic mem_ce;
  logic [15:0] mem_rdata;
  logic [LW-1:0] fifo_level;
  logic starve_forced;
  modport slave (
    input wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    output wr_ready, rd_ack, rd_data, rd_data_valid, mem_addr, mem_wdata, mem_byte_en, mem_we, mem_ce,
    fifo_level, starve_forced
  );
  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
    input wr_ready, rd_ack, rd_data, rd_data_valid, mem_addr, mem_wdata, mem_byte_en, mem_we, mem_ce,
    fifo_level, starve_forced
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port 16-bit framebuffer RAM between a byte writer (via FIFO) and a word reader
module fb_port_arbiter #(
  parameter int PIXEL_WIDTH = 64,
  parameter int PIXEL_HEIGHT = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk_in,
  input logic reset,
  fb_port_if.slave bus
);
  localparam int AW = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL);
  localparam int WW = AW - 1;
  localparam int PW = $clog2(WR_FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [AW-1:0] q_addr [WR_FIFO_DEPTH];
  logic [7:0] q_data [WR_FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [LW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  logic rd_p1, rd_p2;
  logic empty, full, push, grant_rd, grant_wr;
  logic [AW-1:0] head_addr;
  logic [7:0] head_data;
  logic mem_ce, mem_we;
  logic [WW-1:0] mem_addr;
  logic [1:0] mem_byte_en;
  logic [15:0] mem_wdata;
  always_comb begin
    empty = cnt == '0;
    full = cnt == LW'(WR_FIFO_DEPTH);
    push = bus.wr_valid & ~full;
    grant_rd = ~reset & bus.rd_req & (empty | (starve_cnt < SW'(STARVE_LIMIT)));
    grant_wr = ~reset & ~grant_rd & ~empty;
    head_addr = q_addr[rp];
    head_data = q_data[rp];
  end
  always_ff @(posedge clk_in) begin
    if (push) begin
      q_addr[wp] <= bus.wr_addr;
      q_data[wp] <= bus.wr_data;
    end
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      starve_cnt <= '0;
      rd_p1 <= 1'b0;
      rd_p2 <= 1'b0;
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_byte_en <= '0;
      mem_wdata <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(grant_wr);
      cnt <= cnt + LW'(push) - LW'(grant_wr);
      // only reads that bypass queued writes count toward starvation
      starve_cnt <= grant_rd ? ((empty || starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1) : '0;
      rd_p1 <= grant_rd;
      rd_p2 <= rd_p1;
      mem_ce <= grant_rd | grant_wr;
      mem_we <= grant_wr;
      mem_addr <= grant_rd ? bus.rd_addr : head_addr[AW-1:1];
      mem_byte_en <= grant_wr ? (head_addr[0] ? 2'b01 : 2'b10) : 2'b00;
      mem_wdata <= grant_wr ? (head_addr[0] ? {8'h00, head_data} : {head_data, 8'h00}) : '0;
    end
  end
  assign bus.wr_ready = ~full;
  assign bus.rd_ack = grant_rd;
  assign bus.starve_forced = grant_wr & bus.rd_req;
  assign bus.rd_data_valid = rd_p2;
  assign bus.rd_data = rd_p2 ? bus.mem_rdata : '0;
  assign bus.fifo_level = cnt;
  assign bus.mem_ce = mem_ce;
  assign bus.mem_we = mem_we;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_byte_en = mem_byte_en;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: randomized scoreboard bench with a queue-based reference of the arbitration rules and a byte-lane RAM
module tb_fb_port_arbiter;
  localparam int AW = 12, WW = 11, LW = 3, DEPTH = 4, LIMIT = 8;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  always #5 clk_in = ~clk_in;
  fb_port_if #(.AW(AW), .LW(LW)) bus();
  fb_port_arbiter dut (.clk_in(clk_in), .reset(reset), .bus(bus));

  typedef struct { int cyc; bit we; logic [WW-1:0] addr; logic [1:0] be; logic [15:0] wd; } mem_op_t;
  typedef struct { int cyc; logic [15:0] d; } rd_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  mem_op_t exp_mem[$];
  rd_t exp_rd[$];
  wr_t fifo_m[$];
  wr_t wr_src[$];
  logic [WW-1:0] rd_src[$];
  logic [15:0] ram [2**WW];
  logic [15:0] ref_mem [2**WW];
  int cyc = 0, n_tests = 0, n_fail = 0, starve = 0, n_forced = 0, max_level = 0;
  int rd_pct = 0, wr_pct = 0;
  bit rd_granted = 0, wr_taken = 0, rd_always = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) if (bus.mem_ce) begin
    if (bus.mem_we) begin
      if (bus.mem_byte_en[1]) ram[bus.mem_addr][15:8] <= bus.mem_wdata[15:8];
      if (bus.mem_byte_en[0]) ram[bus.mem_addr][7:0] <= bus.mem_wdata[7:0];
    end else bus.mem_rdata <= ram[bus.mem_addr];
  end

  // reference: byte-addressed write queue, read priority, at most LIMIT reads overtake pending writes
  always @(negedge clk_in) begin
    bit grd, gwr, acc;
    wr_t w;
    chk("fifo_level", 32'(bus.fifo_level), fifo_m.size());
    chk("wr_ready", 32'(bus.wr_ready), 32'(fifo_m.size() != DEPTH));
    if (reset) begin
      chk("rd_ack_in_reset", 32'(bus.rd_ack), 0);
      chk("forced_in_reset", 32'(bus.starve_forced), 0);
      fifo_m.delete();
      starve = 0;
      rd_granted = 0;
      wr_taken = 0;
      while (exp_mem.size() != 0 && exp_mem[$].cyc > cyc) void'(exp_mem.pop_back());
      while (exp_rd.size() != 0 && exp_rd[$].cyc > cyc) void'(exp_rd.pop_back());
    end else begin
      acc = bus.wr_valid && fifo_m.size() != DEPTH;
      grd = bus.rd_req && (fifo_m.size() == 0 || starve < LIMIT);
      gwr = !grd && fifo_m.size() != 0;
      chk("rd_ack", 32'(bus.rd_ack), 32'(grd));
      chk("starve_forced", 32'(bus.starve_forced), 32'(gwr && bus.rd_req));
      if (grd) begin
        exp_mem.push_back('{cyc + 1, 1'b0, bus.rd_addr, 2'b00, 16'h0});
        exp_rd.push_back('{cyc + 2, ref_mem[bus.rd_addr]});
        if (fifo_m.size() != 0 && starve < LIMIT) starve++;
      end else if (gwr) begin
        w = fifo_m.pop_front();
        if (w.a[0]) ref_mem[w.a[AW-1:1]][7:0] = w.d;
        else ref_mem[w.a[AW-1:1]][15:8] = w.d;
        exp_mem.push_back('{cyc + 1, 1'b1, w.a[AW-1:1], w.a[0] ? 2'b01 : 2'b10,
                            w.a[0] ? {8'h00, w.d} : {w.d, 8'h00}});
        starve = 0;
        if (bus.rd_req) n_forced++;
      end else starve = 0;
      if (acc) fifo_m.push_back('{bus.wr_addr, bus.wr_data});
      wr_taken = acc;
      rd_granted = grd;
    end
    if (fifo_m.size() > max_level) max_level = fifo_m.size();
  end

  always @(negedge clk_in) begin
    bit hm, hr;
    mem_op_t m;
    rd_t r;
    hm = exp_mem.size() != 0 && exp_mem[0].cyc == cyc;
    hr = exp_rd.size() != 0 && exp_rd[0].cyc == cyc;
    chk("mem_ce", 32'(bus.mem_ce), 32'(hm));
    chk("rd_data_valid", 32'(bus.rd_data_valid), 32'(hr));
    if (hm && bus.mem_ce) begin
      m = exp_mem.pop_front();
      chk("mem_we", 32'(bus.mem_we), 32'(m.we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
      if (m.we) begin
        chk("mem_byte_en", 32'(bus.mem_byte_en), 32'(m.be));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.wd));
      end
    end else if (hm) void'(exp_mem.pop_front());
    if (hr && bus.rd_data_valid) begin
      r = exp_rd.pop_front();
      chk("rd_data", 32'(bus.rd_data), 32'(r.d));
    end else if (hr) void'(exp_rd.pop_front());
  end

  task automatic run(int n);
    wr_t w;
    repeat (n) begin
      @(posedge clk_in);
      #1;
      if (rd_granted || !bus.rd_req) begin
        bus.rd_req = 1'b0;
        if (rd_src.size() != 0) begin
          bus.rd_req = 1'b1;
          bus.rd_addr = rd_src.pop_front();
        end else if (rd_always || $urandom_range(99) < rd_pct) begin
          bus.rd_req = 1'b1;
          bus.rd_addr = WW'($urandom_range(31));
        end
      end
      if (wr_taken || !bus.wr_valid) begin
        bus.wr_valid = 1'b0;
        if (wr_src.size() != 0) begin
          w = wr_src.pop_front();
          bus.wr_valid = 1'b1;
          bus.wr_addr = w.a;
          bus.wr_data = w.d;
        end else if ($urandom_range(99) < wr_pct) begin
          bus.wr_valid = 1'b1;
          bus.wr_addr = AW'($urandom_range(63));
          bus.wr_data = 8'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset(int n);
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    bus.rd_req = 1'b0;
    bus.wr_valid = 1'b0;
    rd_always = 0;
    rd_src.delete();
    wr_src.delete();
    repeat (n) @(posedge clk_in);
    #1;
    reset = 1'b0;
  endtask

  task automatic queue_writes(int n);
    repeat (n) wr_src.push_back('{AW'($urandom_range(63)), 8'($urandom)});
  endtask

  initial begin
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int i = 0; i < 2**WW; i++) begin
      ram[i] = 16'(i * 16'h1357) ^ 16'hA5C3;
      ref_mem[i] = ram[i];
    end
    ram[16] = 16'hF81F;
    ref_mem[16] = 16'hF81F;
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b0;
    run(5);
    wr_src.push_back('{12'h005, 8'hAB});
    run(6);
    rd_src.push_back(11'h010);
    run(6);
    rd_always = 1;
    queue_writes(4);
    run(60);
    rd_always = 0;
    run(5);
    rd_always = 1;
    queue_writes(5);
    run(70);
    rd_always = 0;
    run(5);
    chk("forced_seen", 32'(n_forced >= 9), 1);
    chk("fifo_full_seen", max_level, DEPTH);
    rd_always = 1;
    queue_writes(3);
    run(4);
    do_reset(2);
    run(6);
    rd_pct = 50;
    wr_pct = 60;
    run(3000);
    rd_pct = 95;
    wr_pct = 70;
    run(1500);
    rd_pct = 0;
    wr_pct = 0;
    run(60);
    chk("mem_ops_drained", exp_mem.size(), 0);
    chk("reads_drained", exp_rd.size(), 0);
    chk("fifo_drained", fifo_m.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
